// File: rtl/adc_5g_snapshot.sv
`default_nettype none
// ============================================================================
// Module      : adc_5g_snapshot
// Description : Snapshot capture buffer for the 5 GSps ADC data stream.
//               Arm request, immediate or sync trigger, then capture of
//               capture_len+1 valid 64-bit words, each with its 2-bit
//               overrange flag, into an inferred block RAM. Reads go through
//               a registered port that is usable in any state.
//
// Ports       : ctrl_clk_in     - single clock for the whole block
//               ctrl_reset      - asynchronous active-high reset
//               user_data       - eight 8-bit samples per word
//               user_data_valid - qualifies user_data/user_sync/user_outofrange
//               user_sync       - sync captured on the four ADC clock phases
//               user_outofrange - overrange flags for the word
//               arm             - single-cycle request to start a new capture
//               trig_mode       - 0: first valid word, 1: first valid word
//                                 with any user_sync bit set
//               capture_len     - number of words to capture minus one
//               rd_addr         - readout word address
//               rd_data         - {outofrange, data} at rd_addr, one cycle later
//               busy            - capture armed or in progress
//               done            - capture complete
//               wr_count        - words written in the current capture
//               or_count        - captured words flagged overrange (saturating)
//
// Revision    : 1.0 - initial release
// ============================================================================
module adc_5g_snapshot #(
    parameter int ADDR_W   = 10,
    parameter int OR_CNT_W = 16
) (
    input  logic                ctrl_clk_in,
    input  logic                ctrl_reset,
    input  logic [63:0]         user_data,
    input  logic                user_data_valid,
    input  logic [3:0]          user_sync,
    input  logic [1:0]          user_outofrange,
    input  logic                arm,
    input  logic                trig_mode,
    input  logic [ADDR_W-1:0]   capture_len,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [65:0]         rd_data,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     wr_count,
    output logic [OR_CNT_W-1:0] or_count
);

    localparam int c_DEPTH = 1 << ADDR_W;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    localparam logic [ADDR_W:0]     c_WR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [OR_CNT_W-1:0] c_OR_ONE = {{(OR_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                r_trig_mode;
    logic [ADDR_W-1:0]   r_capture_len;
    logic [ADDR_W:0]     r_wr_count;
    logic [OR_CNT_W-1:0] r_or_count;
    logic [65:0]         r_rd_data;
    logic [65:0]         r_mem [c_DEPTH];

    logic                w_trigger;
    logic                w_wr_en;
    logic                w_last;
    logic [ADDR_W-1:0]   w_wr_addr;

    // While writing, wr_count never exceeds capture_len, so its low bits are
    // the write address. In ARMED it is zero, which places the trigger word
    // at address 0 without a separate mux.
    assign w_wr_addr = r_wr_count[ADDR_W-1:0];
    assign w_last    = (w_wr_addr == r_capture_len);
    assign w_trigger = user_data_valid && (!r_trig_mode || (|user_sync));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and write-enable decode. Arm overrides everything, including
    // the word presented in the same cycle, which is neither stored nor
    // allowed to trigger.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        if (arm) begin
            w_state_next = c_ST_ARMED;
        end else begin
            case (r_state)
                c_ST_ARMED: begin
                    if (w_trigger) begin
                        w_wr_en      = 1'b1;
                        w_state_next = w_last ? c_ST_DONE : c_ST_CAPTURE;
                    end
                end
                c_ST_CAPTURE: begin
                    if (user_data_valid) begin
                        w_wr_en = 1'b1;
                        if (w_last) begin
                            w_state_next = c_ST_DONE;
                        end
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Capture configuration and counters. Configuration is latched on arm so
    // that input changes during a capture have no effect.
    // ------------------------------------------------------------------------
    always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_trig_mode   <= 1'b0;
            r_capture_len <= '0;
            r_wr_count    <= '0;
            r_or_count    <= '0;
        end else if (arm) begin
            r_trig_mode   <= trig_mode;
            r_capture_len <= capture_len;
            r_wr_count    <= '0;
            r_or_count    <= '0;
        end else if (w_wr_en) begin
            r_wr_count <= r_wr_count + c_WR_ONE;
            if ((|user_outofrange) && !(&r_or_count)) begin
                r_or_count <= r_or_count + c_OR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Snapshot memory: simple dual-port block RAM, contents not reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge ctrl_clk_in) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= {user_outofrange, user_data};
        end
    end

    // Registered read; a same-address write in the same cycle returns the
    // previous contents because the array update is non-blocking.
    always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data  = r_rd_data;
    assign busy     = (r_state == c_ST_ARMED) || (r_state == c_ST_CAPTURE);
    assign done     = (r_state == c_ST_DONE);
    assign wr_count = r_wr_count;
    assign or_count = r_or_count;

endmodule
`default_nettype wire

// File: tb/tb_adc_5g_snapshot.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_5g_snapshot
// Description : Self-checking bench for adc_5g_snapshot. Expected words are
//               queued as stimulus is driven and compared on readback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_5g_snapshot;

    localparam int AW = 5;
    localparam int OW = 4;

    logic          ctrl_clk_in = 1'b0;
    logic          ctrl_reset  = 1'b0;
    logic [63:0]   user_data   = '0;
    logic          user_data_valid = 1'b0;
    logic [3:0]    user_sync   = '0;
    logic [1:0]    user_outofrange = '0;
    logic          arm         = 1'b0;
    logic          trig_mode   = 1'b0;
    logic [AW-1:0] capture_len = '0;
    logic [AW-1:0] rd_addr     = '0;
    logic [65:0]   rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
    logic [OW-1:0] or_count;

    int errors = 0;
    int checks = 0;

    logic [65:0] sb [$];
    logic [65:0] shadow [32];

    always #5 ctrl_clk_in = ~ctrl_clk_in;

    adc_5g_snapshot #(
        .ADDR_W   (AW),
        .OR_CNT_W (OW)
    ) dut (
        .ctrl_clk_in     (ctrl_clk_in),
        .ctrl_reset      (ctrl_reset),
        .user_data       (user_data),
        .user_data_valid (user_data_valid),
        .user_sync       (user_sync),
        .user_outofrange (user_outofrange),
        .arm             (arm),
        .trig_mode       (trig_mode),
        .capture_len     (capture_len),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .busy            (busy),
        .done            (done),
        .wr_count        (wr_count),
        .or_count        (or_count)
    );

    task automatic cycle();
        @(posedge ctrl_clk_in);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic push_exp(input int a, input logic [65:0] w);
        sb.push_back(w);
        shadow[a] = w;
    endtask

    task automatic read_word(input int a, output logic [65:0] d);
        rd_addr = AW'(a);
        cycle();
        d = rd_data;
    endtask

    // Arm cycle carries a valid, sync-flagged word that must be ignored.
    task automatic do_arm(input logic mode, input int len);
        arm             = 1'b1;
        trig_mode       = mode;
        capture_len     = AW'(len);
        user_data_valid = 1'b1;
        user_data       = rnd64();
        user_sync       = 4'hF;
        user_outofrange = 2'b11;
        cycle();
        arm             = 1'b0;
        user_data_valid = 1'b0;
        user_sync       = 4'h0;
        user_outofrange = 2'b00;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL rst_wr_count got %0d exp 0", wr_count); end
        checks++; if (or_count !== 4'd0) begin errors++; $display("FAIL rst_or_count got %0d exp 0", or_count); end
        checks++; if (rd_data !== 66'd0) begin errors++; $display("FAIL rst_rd_data got %h exp 0", rd_data); end
        cycle();
        cycle();
        ctrl_reset = 1'b0;
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_immediate();
        logic [65:0] w, got, e;
        do_arm(1'b0, 7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL imm_armed_busy got %b exp 1", busy); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL imm_armed_wr got %0d exp 0", wr_count); end
        // Mid-capture config changes must be ignored (mode 1 with no sync
        // would block the trigger if it were not latched).
        capture_len = AW'(2);
        trig_mode   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            user_data_valid = 1'b1;
            user_data       = 64'(i);
            w = {2'b00, 64'(i)};
            push_exp(i, w);
            cycle();
        end
        user_data_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL imm_done got %b exp 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL imm_busy got %b exp 0", busy); end
        checks++; if (wr_count !== 6'd8) begin errors++; $display("FAIL imm_wr_count got %0d exp 8", wr_count); end
        for (int i = 0; i < 8; i++) begin
            read_word(i, got);
            e = sb.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL imm_rd[%0d] got %h exp %h", i, got, e); end
        end
    endtask

    task automatic test_sync_trigger();
        logic [65:0] w, got, e;
        do_arm(1'b1, 3);
        for (int j = 0; j < 8; j++) begin
            user_data_valid = 1'b1;
            user_data       = rnd64();
            user_sync       = (j == 4) ? 4'b0010 : 4'b0000;
            w = {2'b00, user_data};
            if (j >= 4) push_exp(j - 4, w);
            cycle();
            if (j == 3) begin
                checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL sync_pre_wr got %0d exp 0", wr_count); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sync_pre_busy got %b exp 1", busy); end
            end
        end
        user_data_valid = 1'b0;
        user_sync       = 4'h0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sync_done got %b exp 1", done); end
        checks++; if (wr_count !== 6'd4) begin errors++; $display("FAIL sync_wr_count got %0d exp 4", wr_count); end
        for (int i = 0; i < 4; i++) begin
            read_word(i, got);
            e = sb.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL sync_rd[%0d] got %h exp %h", i, got, e); end
        end
    endtask

    task automatic test_gapped();
        logic [65:0] w, got, e;
        do_arm(1'b0, 3);
        for (int i = 0; i < 7; i++) begin
            user_data_valid = (i % 2 == 0);
            user_data       = rnd64();
            w = {2'b00, user_data};
            if (i % 2 == 0) push_exp(i / 2, w);
            cycle();
            if (i == 5) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_early_done got %b exp 0", done); end
                checks++; if (wr_count !== 6'd3) begin errors++; $display("FAIL gap_mid_wr got %0d exp 3", wr_count); end
            end
        end
        user_data_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done got %b exp 1", done); end
        checks++; if (wr_count !== 6'd4) begin errors++; $display("FAIL gap_wr_count got %0d exp 4", wr_count); end
        for (int i = 0; i < 4; i++) begin
            read_word(i, got);
            e = sb.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL gap_rd[%0d] got %h exp %h", i, got, e); end
        end
    endtask

    task automatic test_overrange();
        logic [65:0] w, got, e;
        do_arm(1'b0, 19);
        for (int i = 0; i < 20; i++) begin
            user_data_valid = 1'b1;
            user_data       = rnd64();
            user_outofrange = 2'b01;
            w = {2'b01, user_data};
            push_exp(i, w);
            cycle();
            if (i == 13) begin
                checks++; if (or_count !== 4'hE) begin errors++; $display("FAIL or_14 got %h exp e", or_count); end
            end
            if (i == 14) begin
                checks++; if (or_count !== 4'hF) begin errors++; $display("FAIL or_15 got %h exp f", or_count); end
            end
        end
        user_data_valid = 1'b0;
        user_outofrange = 2'b00;
        checks++; if (or_count !== 4'hF) begin errors++; $display("FAIL or_sat got %h exp f", or_count); end
        checks++; if (wr_count !== 6'd20) begin errors++; $display("FAIL or_wr_count got %0d exp 20", wr_count); end
        for (int i = 0; i < 20; i++) begin
            read_word(i, got);
            e = sb.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL or_rd[%0d] got %h exp %h", i, got, e); end
        end
    endtask

    task automatic test_collision();
        logic [65:0] w, got, e, old;
        do_arm(1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            rd_addr         = AW'(i);
            old             = shadow[i];
            user_data_valid = 1'b1;
            user_data       = rnd64();
            w = {2'b00, user_data};
            cycle();
            got = rd_data;
            checks++; if (got !== old) begin errors++; $display("FAIL rdw_old[%0d] got %h exp %h", i, got, old); end
            push_exp(i, w);
        end
        user_data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_word(i, got);
            e = sb.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL rdw_new[%0d] got %h exp %h", i, got, e); end
        end
    endtask

    task automatic test_rearm();
        logic [65:0] w, got, e;
        do_arm(1'b0, 7);
        for (int i = 0; i < 3; i++) begin
            user_data_valid = 1'b1;
            user_data       = rnd64();
            user_outofrange = 2'b10;
            w = {2'b10, user_data};
            push_exp(i, w);
            cycle();
        end
        checks++; if (wr_count !== 6'd3) begin errors++; $display("FAIL rearm_pre_wr got %0d exp 3", wr_count); end
        checks++; if (or_count !== 4'd3) begin errors++; $display("FAIL rearm_pre_or got %0d exp 3", or_count); end
        arm             = 1'b1;
        user_data       = rnd64();
        cycle();
        arm             = 1'b0;
        user_outofrange = 2'b00;
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL rearm_wr got %0d exp 0", wr_count); end
        checks++; if (or_count !== 4'd0) begin errors++; $display("FAIL rearm_or got %0d exp 0", or_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rearm_busy got %b exp 1", busy); end
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            user_data_valid = 1'b1;
            user_data       = rnd64();
            w = {2'b00, user_data};
            push_exp(i, w);
            cycle();
        end
        user_data_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rearm_done got %b exp 1", done); end
        checks++; if (wr_count !== 6'd8) begin errors++; $display("FAIL rearm_wr_end got %0d exp 8", wr_count); end
        for (int i = 0; i < 8; i++) begin
            read_word(i, got);
            e = sb.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL rearm_rd[%0d] got %h exp %h", i, got, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [65:0] w, got;
        do_arm(1'b0, 7);
        for (int i = 0; i < 5; i++) begin
            user_data_valid = 1'b1;
            user_data       = rnd64();
            user_outofrange = 2'b11;
            w = {2'b11, user_data};
            push_exp(i, w);
            cycle();
        end
        sb.delete();
        checks++; if (wr_count !== 6'd5) begin errors++; $display("FAIL rmid_pre_wr got %0d exp 5", wr_count); end
        ctrl_reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", done); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL rmid_wr got %0d exp 0", wr_count); end
        checks++; if (or_count !== 4'd0) begin errors++; $display("FAIL rmid_or got %0d exp 0", or_count); end
        checks++; if (rd_data !== 66'd0) begin errors++; $display("FAIL rmid_rd got %h exp 0", rd_data); end
        cycle();
        ctrl_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            user_data_valid = 1'b1;
            user_data       = rnd64();
            cycle();
        end
        user_data_valid = 1'b0;
        user_outofrange = 2'b00;
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL rmid_post_wr got %0d exp 0", wr_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_post_busy got %b exp 0", busy); end
        for (int i = 0; i < 8; i++) begin
            read_word(i, got);
            checks++; if (got !== shadow[i]) begin errors++; $display("FAIL rmid_rd[%0d] got %h exp %h", i, got, shadow[i]); end
        end
    endtask

    task automatic test_full_fill();
        logic [65:0] w, got, e;
        do_arm(1'b0, 31);
        for (int i = 0; i < 32; i++) begin
            user_data_valid = 1'b1;
            user_data       = rnd64();
            w = {2'b00, user_data};
            push_exp(i, w);
            cycle();
            if (i == 30) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL fill_early_done got %b exp 0", done); end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL fill_done got %b exp 1", done); end
        checks++; if (wr_count !== 6'd32) begin errors++; $display("FAIL fill_wr got %0d exp 32", wr_count); end
        // Valid words after DONE must not be written anywhere.
        for (int i = 0; i < 3; i++) begin
            user_data = rnd64();
            cycle();
        end
        user_data_valid = 1'b0;
        checks++; if (wr_count !== 6'd32) begin errors++; $display("FAIL fill_hold_wr got %0d exp 32", wr_count); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL fill_hold_done got %b exp 1", done); end
        for (int i = 0; i < 32; i++) begin
            read_word(i, got);
            e = sb.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL fill_rd[%0d] got %h exp %h", i, got, e); end
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_sync_trigger();
        test_gapped();
        test_overrange();
        test_collision();
        test_rearm();
        test_reset_mid();
        test_full_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_5g_snapshot.md
ADC_5G_SNAPSHOT -- requirements
Module: adc_5g_snapshot

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of snapshot depth in 64-bit words (depth = 2^ADDR_W).
REQ-002 SHALL have parameter OR_CNT_W, default 16, meaning width of the overrange counter.
REQ-003 SHALL have port ctrl_clk_in, input, 1, the single clock for the whole block (same clock that reads the ADC clock-domain FIFO).
REQ-004 SHALL have port ctrl_reset, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port user_data, input, 64, eight 8-bit samples per word, passed through unmodified.
REQ-006 SHALL have port user_data_valid, input, 1, high = user_data/user_sync/user_outofrange valid this cycle.
REQ-007 SHALL have port user_sync, input, 4, sync captured on the four ADC clock phases.
REQ-008 SHALL have port user_outofrange, input, 2, overrange flags for the word.
REQ-009 SHALL have port arm, input, 1, single-cycle request to start a new capture.
REQ-010 SHALL have port trig_mode, input, 1: 0 = start on first valid word, 1 = start on first valid word with any user_sync bit set.
REQ-011 SHALL have port capture_len, input, ADDR_W, number of words to capture minus one.
REQ-012 SHALL have port rd_addr, input, ADDR_W, readout word address.
REQ-013 SHALL have port rd_data, output, 66, {outofrange[1:0], data[63:0]} stored at rd_addr.
REQ-014 SHALL have port busy, output, 1, high in ARMED or CAPTURE.
REQ-015 SHALL have port done, output, 1, high in DONE.
REQ-016 SHALL have port wr_count, output, ADDR_W+1, words written in current capture.
REQ-017 SHALL have port or_count, output, OR_CNT_W, captured words with any outofrange bit set.

Function
REQ-018 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-019 SHALL, on arm=1 in any state, enter ARMED next cycle and clear wr_count and or_count; a valid word in the arm cycle SHALL NOT be captured or trigger.
REQ-020 SHALL, in ARMED, trigger on a valid word meeting trig_mode; the triggering word SHALL be written at address 0 in that cycle and state SHALL go to CAPTURE (or DONE if capture_len=0).
REQ-021 SHALL, in CAPTURE, write each valid word at address wr_count and increment wr_count; invalid cycles SHALL write nothing and hold state.
REQ-022 SHALL enter DONE the cycle after the write at address capture_len; wr_count SHALL then equal capture_len+1.
REQ-023 SHALL sample capture_len and trig_mode on arm and hold them until next arm; mid-capture changes SHALL have no effect.
REQ-024 SHALL remain in DONE until arm; no writes in IDLE or DONE.
REQ-025 SHALL increment or_count for each captured word with user_outofrange != 0, saturating at all-ones.
REQ-026 SHALL deliver rd_data one cycle after rd_addr (registered read); reads allowed in any state; unwritten locations return unspecified data.
REQ-027 SHALL, on read and write of the same address in one cycle, return the old contents.
REQ-028 SHALL use inferred block RAM, depth 2^ADDR_W x 66; capture_len = 2^ADDR_W-1 SHALL fill the buffer with no wrap-around.

Reset
REQ-029 SHALL, on ctrl_reset, asynchronously force state IDLE, busy=0, done=0, wr_count=0, or_count=0, rd_data=0; memory contents not reset.
REQ-030 SHALL, on ctrl_reset during CAPTURE, abort without further writes; capture restarts only on a later arm.

Verification
REQ-031 Immediate: trig_mode=0, capture_len=7, arm, continuous valid ramp 0..; -> addresses 0..7 hold words arriving 1..8 cycles after arm, done=1, wr_count=8.
REQ-032 Sync trigger: trig_mode=1, capture_len=3, user_sync=4'b0010 on the 5th valid word after arm -> address 0 holds that word, DONE after 4 writes.
REQ-033 Gapped valid: user_data_valid toggling 1,0,1,0, capture_len=3 -> exactly 4 words stored in order, DONE 7 cycles after trigger.
REQ-034 Overrange: OR_CNT_W=4, 20 captured words all with outofrange=2'b01 -> or_count=4'hF, rd_data[65:64]=2'b01.
REQ-035 Re-arm mid-capture: arm at wr_count=3 -> wr_count=0 next cycle, capture restarts at address 0, or_count cleared.
REQ-036 Reset mid-capture: ctrl_reset asserted at wr_count=5 -> all outputs 0 immediately, no writes after release until arm.
